jtcop_snd_cmd: RTL

JTCOP_SND_CMD -- requirements
Module: jtcop_snd_cmd

---
 rtl/jtcop_snd_cmd.sv | 139 +++++++++++++
 1 files changed

// File: rtl/jtcop_snd_cmd.sv
// Main-CPU to sound-CPU command transmitter: a small byte FIFO drained one
// byte at a time into a latch, with a timed request pulse and an acknowledge/timeout handshake.
module jtcop_snd_cmd #(
  parameter int FIFO_AW = 2,
  parameter int REQ_LEN = 4,
  parameter int TIMEOUT = 48000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_we,
  input  logic [7:0] cpu_dout,
  input  logic       latch_rd,
  input  logic       clr_ovf,
  output logic [7:0] latch,
  output logic       snreq,
  output logic [7:0] status,
  output logic       ovf
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]       REQ_INIT = 4'(REQ_LEN);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [7:0]         latch_q, latch_d;
  logic [3:0]         pulse_q, pulse_d;
  logic [15:0]        wcnt_q, wcnt_d;
  logic               ack_q, ack_d;
  logic               ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic               full, empty, pop, push;
  logic [2:0]         cnt_sat;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == IDLE) && !empty;
  // A write into a full FIFO still fits when the head leaves in the same cycle.
  assign push  = cpu_we && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (cpu_we && full && !pop) ovf_d = 1'b1;
    else if (clr_ovf)           ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    pulse_d = pulse_q;
    wcnt_d  = wcnt_q;
    ack_d   = ack_q;
    tmo_d   = clr_ovf ? 1'b0 : tmo_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          latch_d = mem_q[rd_q];
          pulse_d = REQ_INIT;
          ack_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        ack_d = ack_q | latch_rd;
        if (pulse_q <= 4'd1) begin
          pulse_d = '0;
          wcnt_d  = '0;
          state_d = (ack_q | latch_rd) ? IDLE : WAIT;
        end else begin
          pulse_d = pulse_q - 1'b1;
        end
      end
      WAIT: begin
        if (latch_rd) begin
          state_d = IDLE;
        end else if (wcnt_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      latch_q <= 8'h00;
      pulse_q <= '0;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      pulse_q <= pulse_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cpu_dout;
  end

  always_comb begin
    if (32'(cnt_q) > 32'd7) cnt_sat = 3'd7;
    else                    cnt_sat = 3'(cnt_q);
  end

  assign latch  = latch_q;
  assign snreq  = (state_q == REQ);
  assign ovf    = ovf_q;
  assign status = {(state_q != IDLE) | !empty, full, empty, ovf_q, tmo_q, cnt_sat};

endmodule
